// File: rtl/array_mrp_clr_pkg.sv
// Shared definitions for the clearable multi-read-port array:
// controller state encoding and the byte-lane width used for write enables.
package array_mrp_clr_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/array_mrp_clr_if.sv
// Bus bundle for array_mrp_clr: one byte-enabled write port, NRD read ports,
// clear request and status pulses. The requester drives the master side.
interface array_mrp_clr_if
  import array_mrp_clr_pkg::*;
#(
  parameter int ADDRBIT = 9,
  parameter int WIDTH   = 32,
  parameter int NRD     = 4
);

  localparam int NBE = WIDTH / BYTE_W;

  logic                     we;
  logic [ADDRBIT-1:0]       wa;
  logic [NBE-1:0]           wbe;
  logic [WIDTH-1:0]         di;
  logic [NRD-1:0]           re;
  logic [NRD*ADDRBIT-1:0]   ra;
  logic [NRD*WIDTH-1:0]     dout;
  logic [NRD-1:0]           dvld;
  logic                     clr_req;
  logic                     busy;
  logic                     clr_done;
  logic                     wr_drop;

  modport master (
    output we, wa, wbe, di, re, ra, clr_req,
    input  dout, dvld, busy, clr_done, wr_drop
  );

  modport slave (
    input  we, wa, wbe, di, re, ra, clr_req,
    output dout, dvld, busy, clr_done, wr_drop
  );

endinterface

// File: rtl/array_mrp_clr_rdport.sv
// One registered read port: selects between the clear value (sweep running),
// zero (address beyond the array), the forwarded write word, or stored data.
module array_mrp_clr_rdport
  import array_mrp_clr_pkg::*;
#(
  parameter int               ADDRBIT = 9,
  parameter int               DEPTH   = 512,
  parameter int               WIDTH   = 32,
  parameter int               BYPASS  = 1,
  parameter logic [WIDTH-1:0] INITVAL = {WIDTH{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               re,
  input  logic [ADDRBIT-1:0] ra,
  input  logic               busy,
  input  logic [WIDTH-1:0]   mem [DEPTH],
  input  logic               wr_ok,
  input  logic [ADDRBIT-1:0] wa,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   dout,
  output logic               dvld
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = DEPTH;

  logic             in_range_s;
  logic [AW-1:0]    idx_s;
  logic [WIDTH-1:0] rdata_s;
  logic [WIDTH-1:0] dout_r;
  logic             dvld_r;

  assign in_range_s = (32'(ra) < DEPTH_U);
  assign idx_s      = in_range_s ? ra[AW-1:0] : {AW{1'b0}};

  // Pick the word this port returns; the sweep wins, then range, then forwarding.
  always_comb begin
    rdata_s = {WIDTH{1'b0}};
    if (busy) begin
      rdata_s = INITVAL;
    end else if (!in_range_s) begin
      rdata_s = {WIDTH{1'b0}};
    end else if ((BYPASS != 0) && wr_ok && (wa == ra)) begin
      rdata_s = wdata;
    end else begin
      rdata_s = mem[idx_s];
    end
  end

  // Output register: data captured only on a request, valid mirrors the request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_r <= {WIDTH{1'b0}};
      dvld_r <= 1'b0;
    end else begin
      dvld_r <= re;
      if (re) begin
        dout_r <= rdata_s;
      end
    end
  end

  assign dout = dout_r;
  assign dvld = dvld_r;

endmodule

// File: rtl/array_mrp_clr.sv
// Multi-read-port word array with byte-enabled writes and a whole-array clear
// sweep. Reset starts a sweep; storage itself is never reset.
module array_mrp_clr
  import array_mrp_clr_pkg::*;
#(
  parameter int               ADDRBIT = 9,
  parameter int               DEPTH   = 512,
  parameter int               WIDTH   = 32,
  parameter int               NRD     = 4,
  parameter int               BYPASS  = 1,
  parameter logic [WIDTH-1:0] INITVAL = {WIDTH{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  array_mrp_clr_if.slave bus
);

  localparam int                 NBE     = WIDTH / BYTE_W;
  localparam int                 AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0]        DEPTH_U = DEPTH;
  localparam logic [ADDRBIT-1:0] LAST    = ADDRBIT'(DEPTH - 1);
  localparam logic [ADDRBIT-1:0] ONE     = ADDRBIT'(1);

  state_e             state_r, state_nxt_s;
  logic [ADDRBIT-1:0] cnt_r, cnt_nxt_s;
  logic [WIDTH-1:0]   mem_r [DEPTH];
  logic               busy_s, sweep_last_s;
  logic               wa_in_range_s, wr_ok_s, wr_bad_s;
  logic [AW-1:0]      wa_idx_s, cnt_idx_s;
  logic [WIDTH-1:0]   wdata_s;
  logic               clr_done_r, wr_drop_r;
  logic [WIDTH-1:0]   dout_s [NRD];

  function automatic logic [WIDTH-1:0] byte_merge(input logic [WIDTH-1:0] old_w,
                                                  input logic [WIDTH-1:0] new_w,
                                                  input logic [NBE-1:0]   be);
    logic [WIDTH-1:0] res;
    res = old_w;
    for (int k = 0; k < NBE; k++) begin
      if (be[k]) begin
        res[k*BYTE_W +: BYTE_W] = new_w[k*BYTE_W +: BYTE_W];
      end else begin
        res[k*BYTE_W +: BYTE_W] = old_w[k*BYTE_W +: BYTE_W];
      end
    end
    return res;
  endfunction

  assign busy_s        = (state_r == ST_CLEAR);
  assign sweep_last_s  = (cnt_r == LAST);
  assign cnt_idx_s     = cnt_r[AW-1:0];
  assign wa_in_range_s = (32'(bus.wa) < DEPTH_U);
  assign wa_idx_s      = wa_in_range_s ? bus.wa[AW-1:0] : {AW{1'b0}};
  assign wr_ok_s       = bus.we && wa_in_range_s && !busy_s;
  assign wr_bad_s      = bus.we && !wr_ok_s;
  assign wdata_s       = byte_merge(mem_r[wa_idx_s], bus.di, bus.wbe);

  // Next state and sweep counter; a clear request during a sweep is ignored.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.clr_req) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
        cnt_nxt_s = {ADDRBIT{1'b0}};
      end
      ST_CLEAR: begin
        if (sweep_last_s) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {ADDRBIT{1'b0}};
        end else begin
          state_nxt_s = ST_CLEAR;
          cnt_nxt_s   = cnt_r + ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {ADDRBIT{1'b0}};
      end
    endcase
  end

  // Controller registers; clr_done is pre-computed so it is high exactly while
  // the last word is being written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_CLEAR;
      cnt_r      <= {ADDRBIT{1'b0}};
      clr_done_r <= 1'b0;
      wr_drop_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      clr_done_r <= (state_nxt_s == ST_CLEAR) && (cnt_nxt_s == LAST);
      wr_drop_r  <= wr_bad_s;
    end
  end

  // Storage: sweep writes the clear value, otherwise accepted byte-merged writes.
  always_ff @(posedge clk) begin
    if (busy_s) begin
      mem_r[cnt_idx_s] <= INITVAL;
    end else if (wr_ok_s) begin
      mem_r[wa_idx_s] <= wdata_s;
    end
  end

  genvar p;
  generate
    for (p = 0; p < NRD; p++) begin : g_rd
      array_mrp_clr_rdport #(
        .ADDRBIT (ADDRBIT),
        .DEPTH   (DEPTH),
        .WIDTH   (WIDTH),
        .BYPASS  (BYPASS),
        .INITVAL (INITVAL)
      ) u_rdport (
        .clk   (clk),
        .rst   (rst),
        .re    (bus.re[p]),
        .ra    (bus.ra[p*ADDRBIT +: ADDRBIT]),
        .busy  (busy_s),
        .mem   (mem_r),
        .wr_ok (wr_ok_s),
        .wa    (bus.wa),
        .wdata (wdata_s),
        .dout  (dout_s[p]),
        .dvld  (bus.dvld[p])
      );
    end
  endgenerate

  // Pack the per-port read words onto the bus.
  always_comb begin
    bus.dout = {(NRD*WIDTH){1'b0}};
    for (int i = 0; i < NRD; i++) begin
      bus.dout[i*WIDTH +: WIDTH] = dout_s[i];
    end
  end

  assign bus.busy     = busy_s;
  assign bus.clr_done = clr_done_r;
  assign bus.wr_drop  = wr_drop_r;

endmodule

// File: tb/tb_array_mrp_clr.sv
// Bench for array_mrp_clr: a forwarding and a non-forwarding instance get the
// same stimulus; a reference array model predicts reads and status pulses, and
// a monitor pops the predictions as the outputs appear.
module tb_array_mrp_clr;

  localparam int D = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  array_mrp_clr_if #(.ADDRBIT(9), .WIDTH(32), .NRD(4)) bus_b ();
  array_mrp_clr_if #(.ADDRBIT(9), .WIDTH(32), .NRD(4)) bus_n ();

  array_mrp_clr #(.ADDRBIT(9), .DEPTH(16), .WIDTH(32), .NRD(4), .BYPASS(1), .INITVAL(32'h0))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
  array_mrp_clr #(.ADDRBIT(9), .DEPTH(16), .WIDTH(32), .NRD(4), .BYPASS(0), .INITVAL(32'h0))
    dut_n (.clk(clk), .rst(rst), .bus(bus_n.slave));

  typedef struct packed { logic busy; logic done; logic drop; } ctl_t;
  typedef struct packed { logic [3:0] mask; logic [127:0] data; } rd_t;

  ctl_t        ctl_q[$];
  rd_t         dq_b[$];
  rd_t         dq_n[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_v [2][4];

  // reference model: array contents plus "sweeping" flag and next sweep address
  logic [31:0] mdl_mem [D];
  bit          mdl_clr = 1'b1;
  int          mdl_pos = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  function automatic logic [35:0] pack4(input int a0, input int a1, input int a2, input int a3);
    logic [8:0] x0, x1, x2, x3;
    x0 = a0[8:0]; x1 = a1[8:0]; x2 = a2[8:0]; x3 = a3[8:0];
    return {x3, x2, x1, x0};
  endfunction

  task automatic drive(input logic we, input int wa, input logic [3:0] wbe, input logic [31:0] di,
                       input logic [3:0] re, input logic [35:0] rap, input logic clr);
    bus_b.we = we; bus_b.wa = wa[8:0]; bus_b.wbe = wbe; bus_b.di = di;
    bus_b.re = re; bus_b.ra = rap; bus_b.clr_req = clr;
    bus_n.we = we; bus_n.wa = wa[8:0]; bus_n.wbe = wbe; bus_n.di = di;
    bus_n.re = re; bus_n.ra = rap; bus_n.clr_req = clr;
  endtask

  // Issue one cycle of stimulus (called at a negedge) and predict its outcome.
  task automatic step(input logic we, input int wa, input logic [3:0] wbe, input logic [31:0] di,
                      input logic [3:0] re, input logic [35:0] rap, input logic clr);
    ctl_t c;
    rd_t rb, rn;
    logic acc;
    logic [31:0] merged, old_v;
    int a;
    drive(we, wa, wbe, di, re, rap, clr);
    acc = !mdl_clr && we && (wa < D);
    merged = 32'h0;
    if (acc) merged = merge_bytes(mdl_mem[wa], di, wbe);
    rb.mask = re; rn.mask = re; rb.data = 128'h0; rn.data = 128'h0;
    for (int p = 0; p < 4; p++) begin
      if (re[p]) begin
        a = int'(rap[p*9 +: 9]);
        old_v = 32'h0;
        if (!mdl_clr && a < D) old_v = mdl_mem[a];
        rn.data[p*32 +: 32] = old_v;
        rb.data[p*32 +: 32] = (acc && a == wa) ? merged : old_v;
      end
    end
    if (re != 4'h0) begin
      dq_b.push_back(rb);
      dq_n.push_back(rn);
    end
    c.drop = we && !acc;
    if (acc) mdl_mem[wa] = merged;
    if (mdl_clr) begin
      mdl_mem[mdl_pos] = 32'h0;
      mdl_pos++;
      if (mdl_pos == D) begin
        mdl_clr = 1'b0;
        mdl_pos = 0;
      end
    end else if (clr) begin
      mdl_clr = 1'b1;
      mdl_pos = 0;
    end
    c.busy = mdl_clr;
    c.done = mdl_clr && (mdl_pos == D - 1);
    ctl_q.push_back(c);
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(1'b0, 0, 4'h0, 32'h0, 4'h0, 36'h0, 1'b0);
  endtask

  task automatic read4(input int a0, input int a1, input int a2, input int a3);
    step(1'b0, 0, 4'h0, 32'h0, 4'hF, pack4(a0, a1, a2, a3), 1'b0);
  endtask

  // Assert reset at a negedge, check outputs clear at once, release after hold cycles.
  task automatic do_reset(input int hold);
    rst = 1'b1;
    drive(1'b0, 0, 4'h0, 32'h0, 4'h0, 36'h0, 1'b0);
    #1;
    chk("rst_busy_b", bus_b.busy, 1'b1);
    chk("rst_busy_n", bus_n.busy, 1'b1);
    chk("rst_dout_b", bus_b.dout, 128'h0);
    chk("rst_dout_n", bus_n.dout, 128'h0);
    chk("rst_dvld", {bus_b.dvld, bus_n.dvld}, 8'h0);
    chk("rst_pulses", {bus_b.clr_done, bus_b.wr_drop, bus_n.clr_done, bus_n.wr_drop}, 4'h0);
    repeat (hold) @(negedge clk);
    rst = 1'b0;
    mdl_clr = 1'b1;
    mdl_pos = 0;
  endtask

  // Compare one instance's read outputs against the oldest prediction.
  task automatic mon_dut(input int d, input logic [3:0] dvld, input logic [127:0] dout);
    rd_t e;
    bit have;
    have = 1'b0;
    if (dvld != 4'h0) begin
      if (d == 0 && dq_b.size() > 0) begin e = dq_b.pop_front(); have = 1'b1; end
      if (d == 1 && dq_n.size() > 0) begin e = dq_n.pop_front(); have = 1'b1; end
      if (!have) begin
        total++; bad++;
        $display("FAIL dvld_unexpected dut%0d: got %h want 0", d, dvld);
        for (int p = 0; p < 4; p++) last_v[d][p] = dout[p*32 +: 32];
      end else begin
        chk($sformatf("dvld_dut%0d", d), dvld, e.mask);
        for (int p = 0; p < 4; p++) begin
          if (e.mask[p]) begin
            chk($sformatf("rdata_dut%0d_p%0d", d, p), dout[p*32 +: 32], e.data[p*32 +: 32]);
            last_v[d][p] = e.data[p*32 +: 32];
          end
        end
      end
    end
    for (int p = 0; p < 4; p++) begin
      if (!dvld[p]) chk($sformatf("hold_dut%0d_p%0d", d, p), dout[p*32 +: 32], last_v[d][p]);
    end
  endtask

  // Monitor: after every active edge, pop and check whatever the DUTs present.
  initial begin
    ctl_t c;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        for (int d = 0; d < 2; d++) for (int p = 0; p < 4; p++) last_v[d][p] = 32'h0;
      end else if (ctl_q.size() > 0) begin
        c = ctl_q.pop_front();
        chk("busy_b", bus_b.busy, c.busy);
        chk("busy_n", bus_n.busy, c.busy);
        chk("clr_done_b", bus_b.clr_done, c.done);
        chk("clr_done_n", bus_n.clr_done, c.done);
        chk("wr_drop_b", bus_b.wr_drop, c.drop);
        chk("wr_drop_n", bus_n.wr_drop, c.drop);
        mon_dut(0, bus_b.dvld, bus_b.dout);
        mon_dut(1, bus_n.dvld, bus_n.dout);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  // Stimulus sequence.
  initial begin
    int guard;
    logic [3:0] re_r;
    drive(1'b0, 0, 4'h0, 32'h0, 4'h0, 36'h0, 1'b0);
    @(negedge clk);
    do_reset(2);
    // post-reset sweep, then read the whole array
    repeat (17) idle_step();
    for (int a = 0; a < D; a += 4) read4(a, a + 1, a + 2, a + 3);
    // byte-enabled update
    step(1'b1, 3, 4'hF, 32'hAABBCCDD, 4'h0, 36'h0, 1'b0);
    step(1'b1, 3, 4'b0010, 32'h11223344, 4'h0, 36'h0, 1'b0);
    read4(3, 3, 3, 3);
    // write with all ports reading the same address in that cycle
    step(1'b1, 5, 4'hF, 32'hDEADBEEF, 4'hF, pack4(5, 5, 5, 5), 1'b0);
    read4(5, 5, 3, 4);
    // out-of-range write and read
    step(1'b1, 20, 4'hF, 32'h12345678, 4'h0, 36'h0, 1'b0);
    read4(20, 3, 5, 15);
    // clear after writes, with a write and reads during the sweep
    step(1'b1, 7, 4'hF, 32'h0BADF00D, 4'h0, 36'h0, 1'b0);
    step(1'b1, 15, 4'hF, 32'hCAFEBABE, 4'h0, 36'h0, 1'b0);
    step(1'b0, 0, 4'h0, 32'h0, 4'h0, 36'h0, 1'b1);
    step(1'b1, 2, 4'hF, 32'h55555555, 4'hF, pack4(7, 15, 3, 2), 1'b0);
    step(1'b0, 0, 4'h0, 32'h0, 4'h0, 36'h0, 1'b1);
    guard = 0;
    while (mdl_clr && guard < 40) begin idle_step(); guard++; end
    idle_step();
    for (int a = 0; a < D; a += 4) read4(a, a + 1, a + 2, a + 3);
    // reset in the middle of a sweep
    step(1'b1, 9, 4'hF, 32'h13579BDF, 4'h0, 36'h0, 1'b0);
    read4(9, 9, 9, 9);
    step(1'b0, 0, 4'h0, 32'h0, 4'h0, 36'h0, 1'b1);
    guard = 0;
    while (mdl_pos != 7 && guard < 20) begin idle_step(); guard++; end
    do_reset(1);
    repeat (17) idle_step();
    for (int a = 0; a < D; a += 4) read4(a, a + 1, a + 2, a + 3);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      re_r = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 2) != 0), int'($urandom_range(0, 19)), 4'($urandom_range(0, 15)),
           $urandom(), re_r,
           pack4(int'($urandom_range(0, 19)), int'($urandom_range(0, 19)),
                 int'($urandom_range(0, 19)), int'($urandom_range(0, 19))),
           ($urandom_range(0, 39) == 0));
    end
    repeat (2) idle_step();
    chk("ctl_queue_drained", ctl_q.size(), 0);
    chk("rd_queue_drained_b", dq_b.size(), 0);
    chk("rd_queue_drained_n", dq_n.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
